// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM encoding, J-type field width and word shift.
package pc_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int J_IDX_W = 26;
  localparam int SHIFT   = 2;

  function automatic logic misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_shadow_stack.sv
// Circular return-address stack: push/pop/compare in one cycle, err registered one cycle later.
// A push when full overwrites the oldest entry; a pop when empty only raises err.
module pc_shadow_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic [WIDTH-1:0]           cmp_dat,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic             empty;
  logic             full;
  logic             mismatch;

  assign top_idx  = ptr - PW'(1);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign mismatch = (mem[top_idx] != cmp_dat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      err <= pop && (empty || mismatch);
      if (pop && !empty) begin
        // Pop+push replaces the top entry in place: pointer and count stay put.
        if (!push) begin
          ptr   <= top_idx;
          count <= count - CW'(1);
        end
      end else if (push) begin
        ptr <= ptr + PW'(1);
        if (!full) begin
          count <= count + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[(pop && !empty) ? top_idx : ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: one-cycle redirect latency, Stall freezes all state, HALT/FAULT exit only by Reset.
// Optional shadow call stack built when PC_SHADOW_STACK_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INCR  = 4,
  parameter int DEPTH = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           StartPC,
  input  logic                       Stall,
  input  logic                       Branch,
  input  logic                       Zero,
  input  logic [WIDTH-1:0]           Immed,
  input  logic                       Jump,
  input  logic [J_IDX_W-1:0]         JumpTarget,
  input  logic                       JumpReg,
  input  logic [WIDTH-1:0]           RegTarget,
  input  logic                       Link,
  input  logic                       Return,
  input  logic                       Halt,
  output logic [WIDTH-1:0]           PC,
  output logic [WIDTH-1:0]           PCPlus4,
  output logic                       Halted,
  output logic                       Fault,
  output logic                       StackErr,
  output logic [$clog2(DEPTH+1)-1:0] StackCount
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] redirect_tgt;
  logic             redirect;
  logic             stack_en;

  assign pc_plus4   = pc + WIDTH'(INCR);
  assign branch_tgt = pc_plus4 + (Immed << SHIFT);
  assign jump_tgt   = {pc_plus4[WIDTH-1:J_IDX_W+SHIFT], JumpTarget, {SHIFT{1'b0}}};

  always_comb begin
    redirect     = 1'b1;
    redirect_tgt = RegTarget;
    if (JumpReg) begin
      redirect_tgt = RegTarget;
    end else if (Jump) begin
      redirect_tgt = jump_tgt;
    end else if (Branch && Zero) begin
      redirect_tgt = branch_tgt;
    end else begin
      redirect     = 1'b0;
      redirect_tgt = pc_plus4;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    stack_en  = 1'b0;
    case (state)
      RUN: begin
        if (!Stall) begin
          // Halt outranks a misaligned redirect; neither touches the stack.
          if (Halt) begin
            state_nxt = HALT;
          end else if (redirect && misaligned(redirect_tgt[1:0])) begin
            state_nxt = FAULT;
          end else begin
            pc_nxt   = redirect_tgt;
            stack_en = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      pc    <= StartPC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  assign PC      = pc;
  assign PCPlus4 = pc_plus4;
  assign Halted  = (state == HALT);
  assign Fault   = (state == FAULT);

`ifdef PC_SHADOW_STACK_EN
  pc_shadow_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_shadow_stack (
    .clk      (Clock),
    .rst      (Reset),
    .push     (stack_en && Link),
    .pop      (stack_en && Return),
    .push_dat (pc_plus4),
    .cmp_dat  (RegTarget),
    .err      (StackErr),
    .count    (StackCount)
  );
`else
  logic unused_stack;
  assign unused_stack = Link ^ Return ^ stack_en;
  assign StackErr     = 1'b0;
  assign StackCount   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; stack expectations follow PC_SHADOW_STACK_EN.
module tb_pc_sequencer;

`ifdef PC_SHADOW_STACK_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] StartPC;
  logic        Stall, Branch, Zero, Jump, JumpReg, Link, Return, Halt;
  logic [31:0] Immed, RegTarget;
  logic [25:0] JumpTarget;
  logic [31:0] PC, PCPlus4;
  logic        Halted, Fault, StackErr;
  logic [3:0]  StackCount;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(32), .INCR(4), .DEPTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .StartPC(StartPC), .Stall(Stall),
    .Branch(Branch), .Zero(Zero), .Immed(Immed), .Jump(Jump),
    .JumpTarget(JumpTarget), .JumpReg(JumpReg), .RegTarget(RegTarget),
    .Link(Link), .Return(Return), .Halt(Halt), .PC(PC), .PCPlus4(PCPlus4),
    .Halted(Halted), .Fault(Fault), .StackErr(StackErr), .StackCount(StackCount)
  );

  always #5 Clock = ~Clock;

  task automatic clear_inputs();
    Stall = 0; Branch = 0; Zero = 0; Jump = 0; JumpReg = 0;
    Link = 0; Return = 0; Halt = 0;
    Immed = '0; RegTarget = '0; JumpTarget = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_to(input logic [31:0] start);
    clear_inputs();
    StartPC = start;
    Reset = 1;
    step();
    Reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    StartPC = 32'h0040_0000;
    Reset = 1;
    #1;
    checks++; if (PC !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0040_0000); end
    checks++; if (PCPlus4 !== 32'h0040_0004) begin errors++; $display("FAIL reset_pcplus4: got %h want %h", PCPlus4, 32'h0040_0004); end
    checks++; if ({Halted, Fault, StackErr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {Halted, Fault, StackErr}); end
    checks++; if (StackCount !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", StackCount); end
    step();
    Reset = 0;
  endtask

  task automatic test_sequential();
    repeat (3) step();
    checks++; if (PC !== 32'h0040_000C) begin errors++; $display("FAIL seq_pc: got %h want %h", PC, 32'h0040_000C); end
    checks++; if (PCPlus4 !== 32'h0040_0010) begin errors++; $display("FAIL seq_pcplus4: got %h want %h", PCPlus4, 32'h0040_0010); end
    reset_to(32'hFFFF_FFFC);
    checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4: got %h want 0", PCPlus4); end
    step();
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", PC); end
  endtask

  task automatic test_branch_jump();
    reset_to(32'h100);
    Branch = 1; Zero = 1; Immed = 32'hFFFF_FFFE;
    step();
    checks++; if (PC !== 32'hFC) begin errors++; $display("FAIL branch_taken: got %h want %h", PC, 32'hFC); end
    clear_inputs();
    Jump = 1; JumpTarget = 26'h40;
    step();
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL jump: got %h want %h", PC, 32'h100); end
    clear_inputs();
    Branch = 1; Zero = 0; Immed = 32'h10;
    step();
    checks++; if (PC !== 32'h104) begin errors++; $display("FAIL branch_not_taken: got %h want %h", PC, 32'h104); end
  endtask

  task automatic test_priority_stall();
    clear_inputs();
    JumpReg = 1; RegTarget = 32'h800; Jump = 1; JumpTarget = 26'h40;
    Branch = 1; Zero = 1; Immed = 32'hFFFF_FFFE;
    step();
    checks++; if (PC !== 32'h800) begin errors++; $display("FAIL priority: got %h want %h", PC, 32'h800); end
    Stall = 1; Halt = 1;
    step();
    checks++; if (PC !== 32'h800) begin errors++; $display("FAIL stall_pc: got %h want %h", PC, 32'h800); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL stall_halt: got %b want 0", Halted); end
  endtask

  task automatic test_halt();
    clear_inputs();
    Halt = 1; Jump = 1; JumpTarget = 26'h40;
    step();
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", Halted); end
    checks++; if (PC !== 32'h800) begin errors++; $display("FAIL halt_wins: got %h want %h", PC, 32'h800); end
    Halt = 0; JumpReg = 1; RegTarget = 32'h802;
    repeat (5) step();
    checks++; if (PC !== 32'h800) begin errors++; $display("FAIL halt_frozen: got %h want %h", PC, 32'h800); end
    checks++; if ({Halted, Fault} !== 2'b10) begin errors++; $display("FAIL halt_state: got %b want 10", {Halted, Fault}); end
  endtask

  task automatic test_fault();
    reset_to(32'h100);
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_exit_by_reset: got %b want 0", Halted); end
    Link = 1;
    step();
    checks++; if (StackCount !== (SS ? 4'd1 : 4'd0)) begin errors++; $display("FAIL fault_pre_count: got %0d want %0d", StackCount, SS ? 1 : 0); end
    JumpReg = 1; RegTarget = 32'h802;
    step();
    checks++; if (Fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b want 1", Fault); end
    checks++; if (PC !== 32'h104) begin errors++; $display("FAIL fault_pc: got %h want %h", PC, 32'h104); end
    checks++; if (StackCount !== (SS ? 4'd1 : 4'd0)) begin errors++; $display("FAIL fault_count: got %0d want %0d", StackCount, SS ? 1 : 0); end
    clear_inputs();
    Jump = 1; JumpTarget = 26'h80;
    repeat (2) step();
    checks++; if (PC !== 32'h104 || Fault !== 1'b1) begin errors++; $display("FAIL fault_frozen: got pc %h fault %b want 104/1", PC, Fault); end
  endtask

  task automatic test_shadow_stack();
    reset_to(32'h200);
    Link = 1; Jump = 1; JumpTarget = 26'h100;
    step();
    checks++; if (PC !== 32'h400 || StackCount !== (SS ? 4'd1 : 4'd0)) begin errors++; $display("FAIL call: got pc %h cnt %0d", PC, StackCount); end
    clear_inputs();
    Return = 1; JumpReg = 1; RegTarget = 32'h204;
    step();
    checks++; if (PC !== 32'h204 || StackErr !== 1'b0 || StackCount !== 4'd0) begin errors++; $display("FAIL ret_match: got pc %h err %b cnt %0d want 204/0/0", PC, StackErr, StackCount); end
    RegTarget = 32'h300;
    step();
    checks++; if (StackErr !== SS || StackCount !== 4'd0 || PC !== 32'h300) begin errors++; $display("FAIL ret_underflow: got err %b cnt %0d pc %h want %b/0/300", StackErr, StackCount, PC, SS); end
    clear_inputs();
    step();
    checks++; if (StackErr !== 1'b0 || PC !== 32'h304) begin errors++; $display("FAIL err_pulse: got err %b pc %h want 0/304", StackErr, PC); end
    Link = 1;
    step();
    clear_inputs();
    Return = 1; JumpReg = 1; RegTarget = 32'h500;
    step();
    checks++; if (StackErr !== SS || StackCount !== 4'd0) begin errors++; $display("FAIL ret_mismatch: got err %b cnt %0d want %b/0", StackErr, StackCount, SS); end
    clear_inputs();
    Link = 1;
    repeat (9) step();
    checks++; if (StackCount !== (SS ? 4'd8 : 4'd0) || PC !== 32'h524) begin errors++; $display("FAIL full_push: got cnt %0d pc %h want %0d/524", StackCount, PC, SS ? 8 : 0); end
    clear_inputs();
    Stall = 1; Return = 1; JumpReg = 1; RegTarget = 32'h999;
    step();
    checks++; if (StackErr !== 1'b0 || StackCount !== (SS ? 4'd8 : 4'd0) || PC !== 32'h524) begin errors++; $display("FAIL stall_ret: got err %b cnt %0d pc %h", StackErr, StackCount, PC); end
    Stall = 0; Link = 1; RegTarget = 32'h524;
    step();
    checks++; if (StackErr !== 1'b0 || StackCount !== (SS ? 4'd8 : 4'd0)) begin errors++; $display("FAIL link_ret: got err %b cnt %0d", StackErr, StackCount); end
    Link = 0; RegTarget = 32'h528;
    step();
    checks++; if (StackErr !== 1'b0 || StackCount !== (SS ? 4'd7 : 4'd0) || PC !== 32'h528) begin errors++; $display("FAIL replaced_top: got err %b cnt %0d pc %h", StackErr, StackCount, PC); end
    RegTarget = 32'h520;
    step();
    checks++; if (StackErr !== 1'b0 || StackCount !== (SS ? 4'd6 : 4'd0)) begin errors++; $display("FAIL stack_order: got err %b cnt %0d", StackErr, StackCount); end
  endtask

  task automatic test_reset_midrun();
    reset_to(32'h100);
    Link = 1;
    repeat (3) step();
    clear_inputs();
    JumpReg = 1; RegTarget = 32'h802;
    step();
    checks++; if (Fault !== 1'b1 || StackCount !== (SS ? 4'd3 : 4'd0)) begin errors++; $display("FAIL midrun_pre: got fault %b cnt %0d", Fault, StackCount); end
    #2;
    StartPC = 32'h0040_0000;
    Reset = 1;
    #1;
    checks++; if (PC !== 32'h0040_0000) begin errors++; $display("FAIL midrun_pc: got %h want %h", PC, 32'h0040_0000); end
    checks++; if ({Halted, Fault, StackErr} !== 3'b000 || StackCount !== 4'd0) begin errors++; $display("FAIL midrun_flags: got %b cnt %0d want 000/0", {Halted, Fault, StackErr}, StackCount); end
    clear_inputs();
    step();
    Reset = 0;
    step();
    checks++; if (PC !== 32'h0040_0004) begin errors++; $display("FAIL post_reset_advance: got %h want %h", PC, 32'h0040_0004); end
  endtask

  initial begin
    Reset = 1;
    StartPC = '0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch_jump();
    test_priority_stall();
    test_halt();
    test_fault();
    test_shadow_stack();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle MIPS datapath. It is the next generation of the existing PC register and supports configurable address width, reset vector input, stall, branch, jump, jump-register, halt and a misaligned-target fault. It also has an optional shadow call stack that checks return addresses. It sits between the instruction memory address port and the control/ALU outputs. It drives the fetch address every cycle and the link value for `jal`/`jalr`.

## Interface
Parameters:
- WIDTH, 32, PC/address width; legal values are 32..64.
- INCR, 4, byte increment per sequential instruction.
- DEPTH, 8, shadow-stack entries; power of two, at least 2.

Ports:
- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset.
- StartPC  in  WIDTH  reset vector, sampled while Reset is high.
- Stall  in  1  hold all state this cycle.
- Branch  in  1  conditional branch instruction.
- Zero  in  1  ALU zero flag.
- Immed  in  WIDTH  sign-extended word offset.
- Jump  in  1  J-type jump.
- JumpTarget  in  26  J-type index field.
- JumpReg  in  1  jump to register (`jr`/`jalr`).
- RegTarget  in  WIDTH  register jump target.
- Link  in  1  call instruction (`jal`/`jalr`); pushes return address.
- Return  in  1  `jr $ra`; pops and checks the return address.
- Halt  in  1  halt instruction.
- PC  out  WIDTH  current fetch address.
- PCPlus4  out  WIDTH  PC + INCR; the link value.
- Halted  out  1  sequencer is in state HALT.
- Fault  out  1  sequencer is in state FAULT.
- StackErr  out  1  one-cycle pulse on a return mismatch or underflow.
- StackCount  out  $clog2(DEPTH+1)  number of valid shadow entries.

## Operation
- Combinational values:
  - PCPlus4 = PC + INCR.
  - BranchTgt = PCPlus4 + (Immed << 2).
  - JumpTgt = {PCPlus4[WIDTH-1:28], JumpTarget, 2'b00}.
- Next-PC priority (highest first): Stall → JumpReg (RegTarget) → Jump (JumpTgt) → Branch & Zero (BranchTgt) → PCPlus4.
- All arithmetic is modulo 2^WIDTH. PC wraps from all-ones to 0 silently.
- FSM states:
  - RUN:
    - Halt & !Stall → HALT; PC holds.
    - Selected redirect target has bits [1:0] ≠ 0 → FAULT; PC holds at the faulting instruction.
    - Otherwise PC ← next PC.
  - HALT: PC frozen; all inputs ignored. Exit only via Reset.
  - FAULT: PC frozen; all inputs ignored. Exit only via Reset.
- Halt and a redirect in the same cycle: Halt wins.
- Stall in RUN: PC, FSM and stack are all unchanged, and StackErr = 0.
- Shadow stack (when compiled in; active only in RUN, !Stall):
  - Link pushes PCPlus4.
  - Full push: overwrites the oldest entry (circular) and StackCount stays at DEPTH.
  - Return pops and compares the top entry with RegTarget. StackErr pulses if they differ, or if the stack is empty (count stays 0).
  - The redirect always follows RegTarget; the check does not alter control flow.
  - Link & Return in the same cycle: pop/compare first, then push, so the top entry is replaced and the count is unchanged.
  - An instruction that goes to FAULT or HALT performs no push or pop.

## Timing
- While Reset is high:
  - PC = StartPC.
  - State = RUN.
  - Halted = 0, Fault = 0, StackErr = 0, StackCount = 0.
  - Stack pointer = 0.
- Reset asserted mid-operation takes effect immediately (asynchronously), including from HALT or FAULT.
- After Reset falls, the first posedge advances PC.
- Latency: one cycle from redirect inputs to the new PC. PCPlus4 is combinational from PC.
- Halted and Fault are registered state decodes. They rise on the posedge that takes the transition.
- StackErr is registered. It is high for exactly the cycle after the offending edge.

## Configuration
- PC_SHADOW_STACK_EN defined: the shadow stack, StackErr and StackCount logic are built.
- PC_SHADOW_STACK_EN undefined: Link and Return are ignored, StackErr = 0 and StackCount = 0. All other behaviour is unchanged.

## Structure
- Shared package `pc_pkg` holds:
  - state encoding (RUN, HALT, FAULT);
  - J_IDX_W = 26;
  - SHIFT = 2 (replaces the standalone left-shift module).
- One sub-module: `pc_shadow_stack` (push/pop/compare circular buffer with count). It is instantiated only under PC_SHADOW_STACK_EN.

## Test plan
- Sequential and wrap: StartPC=0x0040_0000, Reset pulse, 3 edges → PC = 0x0040_000C. With StartPC=0xFFFF_FFFC, one edge → PC = 0.
- Branch and jump: at PC=0x100, Branch=Zero=1, Immed=-2 → PC = 0xFC. Next, Jump with JumpTarget=0x40 → PC = 0x100. Branch=1 with Zero=0 → PC += 4.
- Priority and stall: JumpReg, Jump and taken branch together with RegTarget=0x800 → PC = 0x800. The same inputs plus Stall → PC unchanged.
- Halt and fault: Halt → Halted = 1 and PC frozen for 5 edges despite Jump. After Reset, JumpReg with RegTarget=0x802 → Fault = 1, PC held, StackCount unchanged.
- Shadow stack: Link at PC=0x200, then Return with RegTarget=0x204 → no StackErr, count back to 0. A further Return → StackErr pulses for 1 cycle. 9 Links with DEPTH=8 → StackCount = 8.
- Reset mid-run: assert Reset between edges with StackCount=3 and Fault=1 → all outputs reach reset values before the next edge.
